// File: rtl/io_bus_bridge.sv
// io_bus_bridge
// Terminates the 16-bit io_* host bus, decodes each access to one of N_CH
// peripheral channels or to four internal control registers, bounds every
// channel access with a timeout and aggregates channel interrupts into io_irq.
//
// Optional feature macro: IO_BRIDGE_TIMEOUT_EN
//   defined   -> timeout counter and TIMEOUT_CYCLES register present
//   undefined -> ACCESS waits forever for ch_ack, register 3 reads 0,
//                STATUS bit0 and channel field stay 0
//
// Ports
//   clk_clk, reset_reset        : clock, synchronous active-high reset
//   io_address/io_bus_enable/io_rw/io_byte_enable/io_write_data : host request
//   io_read_data/io_acknowledge : host response (one-cycle ack pulse)
//   io_irq                      : registered OR of masked pending interrupts
//   ch_req/ch_addr/ch_rw/ch_be/ch_wdata : shared channel request bus
//   ch_rdata/ch_ack             : per-channel read data and completion
//   ch_irq                      : per-channel level interrupts
//
// Internal registers (io_address[ADDR_W-1]=1, index io_address[1:0]):
//   0 IRQ_PENDING (W1C), 1 IRQ_MASK, 2 STATUS, 3 TIMEOUT_CYCLES
module io_bus_bridge #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int N_CH      = 4,
  parameter int CH_ADDR_W = 10,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [ADDR_W-1:0]      io_address,
  input  logic                   io_bus_enable,
  input  logic                   io_rw,
  input  logic [DATA_W/8-1:0]    io_byte_enable,
  input  logic [DATA_W-1:0]      io_write_data,
  output logic [DATA_W-1:0]      io_read_data,
  output logic                   io_acknowledge,
  output logic                   io_irq,
  output logic [N_CH-1:0]        ch_req,
  output logic [CH_ADDR_W-1:0]   ch_addr,
  output logic                   ch_rw,
  output logic [DATA_W/8-1:0]    ch_be,
  output logic [DATA_W-1:0]      ch_wdata,
  input  logic [N_CH*DATA_W-1:0] ch_rdata,
  input  logic [N_CH-1:0]        ch_ack,
  input  logic [N_CH-1:0]        ch_irq
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int NB    = DATA_W / 8;
  // The whole field between the channel window and the internal-select bit
  // is decoded, so any value >= N_CH (including upper garbage) is an error.
  localparam int DEC_W = ADDR_W - 1 - CH_ADDR_W;
  localparam logic [DEC_W-1:0] N_CH_DEC = DEC_W'(N_CH);
  localparam logic [N_CH-1:0]  CH_ONE   = N_CH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  state_t               state_q;
  logic [SEL_W-1:0]     sel_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 ack_q;
  logic                 irq_q;
  logic [N_CH-1:0]      req_q;
  logic [CH_ADDR_W-1:0] ch_addr_q;
  logic                 ch_rw_q;
  logic [NB-1:0]        ch_be_q;
  logic [DATA_W-1:0]    ch_wdata_q;

  logic [N_CH-1:0]      pending_q, pending_d;
  logic [N_CH-1:0]      mask_q, mask_d;
  logic [N_CH-1:0]      irq_prev_q;
  logic                 st_to_q, st_to_d;
  logic                 st_derr_q, st_derr_d;
  logic [SEL_W-1:0]     st_ch_q, st_ch_d;

  logic [DATA_W-1:0]    bmask_s;
  logic [DATA_W-1:0]    wr_bits_s;
  logic [DATA_W-1:0]    reg_rdata_s;
  logic [DATA_W-1:0]    ch_rdata_sel_s;
  logic [N_CH-1:0]      rise_s;
  logic [N_CH-1:0]      pend_clr_s;
  logic [1:0]           reg_idx_s;
  logic [SEL_W-1:0]     sel_s;
  logic                 idle_req_s;
  logic                 int_hit_s;
  logic                 dec_err_s;
  logic                 reg_wr_s;
  logic                 ack_sel_s;
  logic                 to_hit_s;
  logic                 to_evt_s;

  assign io_read_data   = rdata_q;
  assign io_acknowledge = ack_q;
  assign io_irq         = irq_q;
  assign ch_req         = req_q;
  assign ch_addr        = ch_addr_q;
  assign ch_rw          = ch_rw_q;
  assign ch_be          = ch_be_q;
  assign ch_wdata       = ch_wdata_q;

  assign idle_req_s     = (state_q == S_IDLE) && io_bus_enable;
  assign int_hit_s      = io_address[ADDR_W-1];
  assign dec_err_s      = !int_hit_s && (io_address[CH_ADDR_W +: DEC_W] >= N_CH_DEC);
  assign sel_s          = io_address[CH_ADDR_W +: SEL_W];
  assign reg_idx_s      = io_address[1:0];
  assign reg_wr_s       = idle_req_s && int_hit_s && !io_rw;
  assign wr_bits_s      = io_write_data & bmask_s;
  assign ack_sel_s      = ch_ack[sel_q];
  assign ch_rdata_sel_s = ch_rdata[sel_q*DATA_W +: DATA_W];
  assign rise_s         = ch_irq & ~irq_prev_q;
  assign to_evt_s       = (state_q == S_ACCESS) && !ack_sel_s && to_hit_s;

`ifdef IO_BRIDGE_TIMEOUT_EN
  logic [DATA_W-1:0] to_cycles_q, to_cycles_d;
  logic [DATA_W-1:0] cnt_q;
  // Abort on the edge where the number of ack-less cycles reaches the limit.
  assign to_hit_s = (to_cycles_q != '0) && ((cnt_q + DATA_W'(1)) == to_cycles_q);
`else
  assign to_hit_s = 1'b0;
`endif

  // Expand byte enables into a per-bit write mask.
  always_comb begin
    bmask_s = '0;
    for (int b = 0; b < NB; b++) begin
      bmask_s[8*b +: 8] = {8{io_byte_enable[b]}};
    end
  end

  // Internal register read mux; unused bits read 0.
  always_comb begin
    reg_rdata_s = '0;
    case (reg_idx_s)
      2'd0: reg_rdata_s[N_CH-1:0] = pending_q;
      2'd1: reg_rdata_s[N_CH-1:0] = mask_q;
      2'd2: begin
        reg_rdata_s[0]         = st_to_q;
        reg_rdata_s[1]         = st_derr_q;
        reg_rdata_s[8 +: SEL_W] = st_ch_q;
      end
`ifdef IO_BRIDGE_TIMEOUT_EN
      2'd3: reg_rdata_s = to_cycles_q;
`else
      2'd3: reg_rdata_s = '0;
`endif
      default: reg_rdata_s = '0;
    endcase
  end

  // Next state of the register bank; a new irq edge beats a W1C clear.
  always_comb begin
    if (reg_wr_s && (reg_idx_s == 2'd0)) begin
      pend_clr_s = wr_bits_s[N_CH-1:0];
    end else begin
      pend_clr_s = '0;
    end
    pending_d = (pending_q & ~pend_clr_s) | rise_s;

    if (reg_wr_s && (reg_idx_s == 2'd1)) begin
      mask_d = (mask_q & ~bmask_s[N_CH-1:0]) | wr_bits_s[N_CH-1:0];
    end else begin
      mask_d = mask_q;
    end

    if (idle_req_s && dec_err_s) begin
      st_derr_d = 1'b1;
    end else if (reg_wr_s && (reg_idx_s == 2'd2) && wr_bits_s[1]) begin
      st_derr_d = 1'b0;
    end else begin
      st_derr_d = st_derr_q;
    end

    if (to_evt_s) begin
      st_to_d = 1'b1;
      st_ch_d = sel_q;
    end else if (reg_wr_s && (reg_idx_s == 2'd2) && wr_bits_s[0]) begin
      st_to_d = 1'b0;
      st_ch_d = st_ch_q;
    end else begin
      st_to_d = st_to_q;
      st_ch_d = st_ch_q;
    end

`ifdef IO_BRIDGE_TIMEOUT_EN
    if (reg_wr_s && (reg_idx_s == 2'd3)) begin
      to_cycles_d = (to_cycles_q & ~bmask_s) | wr_bits_s;
    end else begin
      to_cycles_d = to_cycles_q;
    end
`endif
  end

  // Register bank, irq edge detector and registered irq output.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pending_q   <= '0;
      mask_q      <= '0;
      irq_prev_q  <= '0;
      irq_q       <= 1'b0;
      st_to_q     <= 1'b0;
      st_derr_q   <= 1'b0;
      st_ch_q     <= '0;
`ifdef IO_BRIDGE_TIMEOUT_EN
      to_cycles_q <= DATA_W'(TIMEOUT);
`endif
    end else begin
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      irq_prev_q  <= ch_irq;
      irq_q       <= |(pending_q & mask_q);
      st_to_q     <= st_to_d;
      st_derr_q   <= st_derr_d;
      st_ch_q     <= st_ch_d;
`ifdef IO_BRIDGE_TIMEOUT_EN
      to_cycles_q <= to_cycles_d;
`endif
    end
  end

  // Bus FSM with registered host and channel outputs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      req_q      <= '0;
      ch_addr_q  <= '0;
      ch_rw_q    <= 1'b0;
      ch_be_q    <= '0;
      ch_wdata_q <= '0;
`ifdef IO_BRIDGE_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          if (io_bus_enable) begin
            ch_addr_q  <= io_address[CH_ADDR_W-1:0];
            ch_rw_q    <= io_rw;
            ch_be_q    <= io_byte_enable;
            ch_wdata_q <= io_write_data;
            sel_q      <= sel_s;
            if (int_hit_s) begin
              rdata_q <= io_rw ? reg_rdata_s : '0;
              ack_q   <= 1'b1;
              state_q <= S_RESPOND;
            end else if (dec_err_s) begin
              rdata_q <= '1;
              ack_q   <= 1'b1;
              state_q <= S_RESPOND;
            end else begin
              req_q   <= CH_ONE << sel_s;
`ifdef IO_BRIDGE_TIMEOUT_EN
              cnt_q   <= '0;
`endif
              state_q <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // Ack takes priority over a timeout on the same edge.
          if (ack_sel_s) begin
            rdata_q <= ch_rdata_sel_s;
            req_q   <= '0;
            ack_q   <= 1'b1;
            state_q <= S_RESPOND;
          end else if (to_hit_s) begin
            rdata_q <= '1;
            req_q   <= '0;
            ack_q   <= 1'b1;
            state_q <= S_RESPOND;
          end else begin
`ifdef IO_BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_q + DATA_W'(1);
`endif
            state_q <= S_ACCESS;
          end
        end
        S_RESPOND: begin
          ack_q   <= 1'b0;
          rdata_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!io_bus_enable) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= '0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_bridge.sv
module tb_io_bus_bridge;

  localparam int NC = 4;
`ifdef IO_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_reset;
  logic [15:0] io_address;
  logic        io_bus_enable;
  logic        io_rw;
  logic [1:0]  io_byte_enable;
  logic [15:0] io_write_data;
  logic [15:0] io_read_data;
  logic        io_acknowledge;
  logic        io_irq;
  logic [3:0]  ch_req;
  logic [9:0]  ch_addr;
  logic        ch_rw;
  logic [1:0]  ch_be;
  logic [15:0] ch_wdata;
  logic [63:0] ch_rdata;
  logic [3:0]  ch_ack;
  logic [3:0]  ch_irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: channel memories and the mask register.
  logic [15:0] mem [NC][1024];
  logic [15:0] m_mask;
  logic [15:0] last_rd;
  int          last_req, last_ack_n, last_drv_n;

  logic [1:0]  r_ch;
  logic [9:0]  r_off;
  logic [1:0]  r_be;
  logic [15:0] r_d, r_bm;
  int          r_kind;

  always #5 clk = ~clk;

  io_bus_bridge dut (
    .clk_clk        (clk),
    .reset_reset    (reset_reset),
    .io_address     (io_address),
    .io_bus_enable  (io_bus_enable),
    .io_rw          (io_rw),
    .io_byte_enable (io_byte_enable),
    .io_write_data  (io_write_data),
    .io_read_data   (io_read_data),
    .io_acknowledge (io_acknowledge),
    .io_irq         (io_irq),
    .ch_req         (ch_req),
    .ch_addr        (ch_addr),
    .ch_rw          (ch_rw),
    .ch_be          (ch_be),
    .ch_wdata       (ch_wdata),
    .ch_rdata       (ch_rdata),
    .ch_ack         (ch_ack),
    .ch_irq         (ch_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One host transaction; the bench also plays the addressed channel,
  // acking after 'delay' request cycles (never if delay < 1).
  task automatic bus(input logic [15:0] addr, input logic rw, input logic [1:0] be,
                     input logic [15:0] wd, input int delay, input bit drop);
    int sel, off;
    logic [15:0] bm;
    bit done;
    sel = int'(addr[11:10]);
    off = int'(addr[9:0]);
    bm  = {{8{be[1]}}, {8{be[0]}}};
    last_req = 0; last_ack_n = -1; last_drv_n = -1; last_rd = '0; done = 1'b0;
    @(negedge clk);
    io_address = addr; io_rw = rw; io_byte_enable = be; io_write_data = wd;
    io_bus_enable = 1'b1;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(negedge clk);
      ch_ack = '0;
      if (io_acknowledge) begin
        last_rd = io_read_data; last_ack_n = n; done = 1'b1;
      end else if (ch_req != '0) begin
        last_req++;
        if (last_req == 1) begin
          chk("ch_req one-hot", ch_req, 32'(1) << sel);
          chk("ch_addr", ch_addr, off);
          chk("ch_rw", ch_rw, rw);
          chk("ch_be", ch_be, be);
          chk("ch_wdata", ch_wdata, wd);
          if (drop) io_bus_enable = 1'b0;
        end
        if (last_req == delay) begin
          ch_rdata = {$urandom, $urandom};
          if (rw) ch_rdata[sel*16 +: 16] = mem[sel][off];
          else    mem[sel][off] = (mem[sel][off] & ~bm) | (wd & bm);
          ch_ack[sel] = 1'b1;
          last_drv_n  = n;
        end
      end
    end
    io_bus_enable = 1'b0;
    ch_ack = '0;
    if (!done)                 chk("ack within budget", 32'd0, 32'd1);
    else if (last_drv_n >= 0)  chk("ack latency", last_ack_n, last_drv_n + 1);
    else                       chk("ack latency no channel ack", last_ack_n, last_req + 1);
    @(negedge clk);
    chk("ack single pulse", io_acknowledge, 32'd0);
  endtask

  task automatic reg_wr(input logic [1:0] idx, input logic [1:0] be, input logic [15:0] d);
    bus({1'b1, 13'h0000, idx}, 1'b0, be, d, 0, 1'b0);
  endtask

  task automatic reg_chk(input string tag, input logic [1:0] idx, input logic [15:0] exp_v);
    bus({1'b1, 13'h0000, idx}, 1'b1, 2'b11, 16'h0000, 0, 1'b0);
    chk(tag, last_rd, exp_v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < 1024; a++) mem[c][a] = 16'($urandom);
    reset_reset = 1'b1; io_address = '0; io_bus_enable = 1'b0; io_rw = 1'b0;
    io_byte_enable = '0; io_write_data = '0; ch_rdata = '0; ch_ack = '0; ch_irq = '0;
    m_mask = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset io_acknowledge", io_acknowledge, 32'd0);
    chk("reset io_read_data", io_read_data, 32'd0);
    chk("reset io_irq", io_irq, 32'd0);
    chk("reset ch_req", ch_req, 32'd0);
    chk("reset ch_addr", ch_addr, 32'd0);
    chk("reset ch_wdata", ch_wdata, 32'd0);
    reset_reset = 1'b0;

    reg_chk("reset PENDING", 2'd0, 16'h0000);
    reg_chk("reset MASK", 2'd1, 16'h0000);
    reg_chk("reset STATUS", 2'd2, 16'h0000);
    reg_chk("reset TIMEOUT", 2'd3, TO_EN ? 16'd255 : 16'd0);

    // Channel 2 write then read back with a 3-cycle channel ack.
    bus(16'h0805, 1'b0, 2'b11, 16'h1234, 3, 1'b0);
    bus(16'h0805, 1'b1, 2'b11, 16'h0000, 3, 1'b0);
    chk("ch2 readback", last_rd, 16'h1234);

    // Timeout on channel 1 with TIMEOUT_CYCLES = 8.
    reg_wr(2'd3, 2'b11, 16'd8);
    reg_chk("TIMEOUT write", 2'd3, TO_EN ? 16'd8 : 16'd0);
    bus(16'h0400, 1'b1, 2'b11, 16'h0000, TO_EN ? -1 : 30, 1'b0);
    chk("timeout req cycles", last_req, TO_EN ? 32'd8 : 32'd30);
    chk("timeout read data", last_rd, TO_EN ? 16'hFFFF : mem[1][0]);
    reg_chk("STATUS after timeout", 2'd2, TO_EN ? 16'h0101 : 16'h0000);
    reg_wr(2'd2, 2'b11, 16'h0001);
    reg_chk("STATUS after W1C", 2'd2, TO_EN ? 16'h0100 : 16'h0000);

    // Ack on the same edge as the timeout wins.
    bus(16'h0403, 1'b1, 2'b11, 16'h0000, 8, 1'b0);
    chk("ack vs timeout data", last_rd, mem[1][3]);
    reg_chk("STATUS ack wins", 2'd2, TO_EN ? 16'h0100 : 16'h0000);

    // TIMEOUT_CYCLES = 0 disables the timeout.
    reg_wr(2'd3, 2'b11, 16'd0);
    bus(16'h0011, 1'b1, 2'b11, 16'h0000, 20, 1'b0);
    chk("no timeout req cycles", last_req, 32'd20);
    chk("no timeout data", last_rd, mem[0][17]);
    reg_wr(2'd3, 2'b11, 16'd255);

    // Decode error: field value 5 with four channels.
    bus(16'h1400, 1'b1, 2'b11, 16'h0000, 1, 1'b0);
    chk("decode err no req", last_req, 32'd0);
    chk("decode err data", last_rd, 16'hFFFF);
    reg_chk("STATUS decode err", 2'd2, TO_EN ? 16'h0102 : 16'h0002);
    reg_wr(2'd2, 2'b11, 16'h0002);
    reg_chk("STATUS derr cleared", 2'd2, TO_EN ? 16'h0100 : 16'h0000);

    // Byte-lane writes to MASK; only the low N_CH bits exist.
    reg_wr(2'd1, 2'b10, 16'hABCD);
    reg_chk("MASK upper lane", 2'd1, 16'h0000);
    reg_wr(2'd1, 2'b01, 16'hABCD);
    reg_chk("MASK lower lane", 2'd1, 16'h000D);
    reg_wr(2'd1, 2'b11, 16'h0003);
    m_mask = 16'h0003;

    // Interrupt latency and set-beats-clear.
    @(negedge clk); ch_irq = 4'b0001;
    @(negedge clk); chk("irq after 1 edge", io_irq, 32'd0);
    @(negedge clk); chk("irq after 2 edges", io_irq, 32'd1);
    reg_chk("PENDING set", 2'd0, 16'h0001);
    reg_wr(2'd0, 2'b11, 16'h0001);
    reg_chk("PENDING cleared", 2'd0, 16'h0000);
    chk("irq after clear", io_irq, 32'd0);
    @(negedge clk); ch_irq = 4'b0000;
    @(negedge clk); ch_irq = 4'b0001;
    io_address = 16'h8000; io_rw = 1'b0; io_byte_enable = 2'b11;
    io_write_data = 16'h0001; io_bus_enable = 1'b1;
    @(negedge clk);
    chk("collision write ack", io_acknowledge, 32'd1);
    io_bus_enable = 1'b0;
    @(negedge clk);
    reg_chk("PENDING set wins", 2'd0, 16'h0001);
    ch_irq = 4'b0000;
    reg_wr(2'd0, 2'b11, 16'h000F);
    reg_chk("PENDING final clear", 2'd0, 16'h0000);

    // Host drops enable mid-access; ack still pulses.
    bus(16'h0C22, 1'b1, 2'b11, 16'h0000, 4, 1'b1);
    chk("drop-early data", last_rd, mem[3][34]);

    // Randomised traffic against the model.
    for (int i = 0; i < 40; i++) begin
      r_kind = $urandom_range(0, 2);
      r_ch   = 2'($urandom_range(0, 3));
      r_off  = 10'($urandom);
      r_be   = 2'($urandom_range(1, 3));
      r_d    = 16'($urandom);
      case (r_kind)
        0: begin
          bus({4'b0000, r_ch, r_off}, 1'b0, r_be, r_d, $urandom_range(1, 6), 1'b0);
          bus({4'b0000, r_ch, r_off}, 1'b1, 2'b11, 16'h0000, $urandom_range(1, 6), 1'b0);
          chk("random write-read", last_rd, mem[r_ch][r_off]);
        end
        1: begin
          bus({4'b0000, r_ch, r_off}, 1'b1, 2'b11, 16'h0000, $urandom_range(1, 6), 1'b0);
          chk("random read", last_rd, mem[r_ch][r_off]);
        end
        default: begin
          r_bm   = {{8{r_be[1]}}, {8{r_be[0]}}};
          m_mask = ((m_mask & ~r_bm) | (r_d & r_bm)) & 16'h000F;
          reg_wr(2'd1, r_be, r_d);
          reg_chk("random MASK", 2'd1, m_mask);
        end
      endcase
    end

    // Reset in the middle of a channel access.
    reg_wr(2'd1, 2'b11, 16'h0005);
    reg_wr(2'd3, 2'b11, 16'h0020);
    @(negedge clk);
    io_address = 16'h0000; io_rw = 1'b1; io_byte_enable = 2'b11; io_bus_enable = 1'b1;
    @(negedge clk); chk("req before reset", ch_req, 32'h1);
    @(negedge clk); reset_reset = 1'b1;
    @(negedge clk);
    chk("reset mid-access ch_req", ch_req, 32'd0);
    chk("reset mid-access ack", io_acknowledge, 32'd0);
    chk("reset mid-access read data", io_read_data, 32'd0);
    reset_reset = 1'b0; io_bus_enable = 1'b0;
    reg_chk("post-reset MASK", 2'd1, 16'h0000);
    reg_chk("post-reset STATUS", 2'd2, 16'h0000);
    reg_chk("post-reset PENDING", 2'd0, 16'h0000);
    reg_chk("post-reset TIMEOUT", 2'd3, TO_EN ? 16'd255 : 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
